// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Funct codes, FSM state encoding and request legality helper.
package lsu_pkg;

  localparam int DEPTH_DEF = 32;

  localparam logic [2:0] FUNCT_B  = 3'b000;
  localparam logic [2:0] FUNCT_H  = 3'b001;
  localparam logic [2:0] FUNCT_W  = 3'b010;
  localparam logic [2:0] FUNCT_BU = 3'b100;
  localparam logic [2:0] FUNCT_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LEXT,
    S_MRG,
    S_WR,
    S_ERR
  } state_e;

  // Unsigned widths only exist for loads.
  function automatic logic funct_bad(
    input logic       wr,
    input logic [2:0] f
  );
    logic bad;
    bad = 1'b1;
    case (f)
      FUNCT_B, FUNCT_H, FUNCT_W: bad = 1'b0;
      FUNCT_BU, FUNCT_HU:        bad = wr;
      default:                   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port bundle.
// master: execute stage plus memory model; slave: the LSU.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_funct,
    output req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_error,
    input  resp_rdata, mem_read, mem_write,
    input  mem_address, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_funct,
    input  req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_error,
    output resp_rdata, mem_read, mem_write,
    output mem_address, mem_write_data
  );

endinterface

// File: rtl/lsu_align.sv
// Lane selection: load extension, store merge and alignment check.
// Purely combinational; lanes are little-endian.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct,
  input  logic [31:0] sdata,
  output logic [31:0] ext,
  output logic [31:0] merged,
  output logic        misal
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{lane, 3'b000} +: 8];
    h      = lane[1] ? word[31:16] : word[15:0];
    ext    = word;
    merged = word;
    misal  = 1'b0;
    unique case (1'b1)
      (funct == FUNCT_B): begin
        ext = {{24{b[7]}}, b};
        merged[{lane, 3'b000} +: 8] = sdata[7:0];
      end
      (funct == FUNCT_BU): begin
        ext = {24'h0, b};
      end
      (funct == FUNCT_H): begin
        ext   = {{16{h[15]}}, h};
        misal = lane[0];
        if (lane[1]) merged[31:16] = sdata[15:0];
        else         merged[15:0]  = sdata[15:0];
      end
      (funct == FUNCT_HU): begin
        ext   = {16'h0, h};
        misal = lane[0];
      end
      (funct == FUNCT_W): begin
        misal  = |lane;
        merged = sdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, RMW for B/H.
// FSM with registered request fields and registered response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  state_e state_q, state_d;

  logic             write_q, write_d;
  logic [2:0]       funct_q, funct_d;
  logic [IDX_W+1:0] addr_q, addr_d;
  logic [31:0]      word_q, word_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_error_q, resp_error_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  logic        idle;
  logic [2:0]  a_funct;
  logic [1:0]  a_lane;
  logic [31:0] a_ext;
  logic [31:0] a_merged;
  logic        a_misal;
  logic        out_rng;
  logic        illegal;

  assign idle = (state_q == S_IDLE);

  // In IDLE the aligner checks the incoming request; later it
  // works on the registered fields and the returned word.
  assign a_funct = idle ? bus.req_funct     : funct_q;
  assign a_lane  = idle ? bus.req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .word   (bus.mem_read_data),
    .lane   (a_lane),
    .funct  (a_funct),
    .sdata  (word_q),
    .ext    (a_ext),
    .merged (a_merged),
    .misal  (a_misal)
  );

  assign out_rng = bus.req_addr[31:2] >= 30'(DEPTH);
  assign illegal = funct_bad(bus.req_write, bus.req_funct)
                 | a_misal | out_rng;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct_d      = funct_q;
    addr_d       = addr_q;
    word_d       = word_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          funct_d = bus.req_funct;
          addr_d  = bus.req_addr[IDX_W+1:0];
          word_d  = bus.req_wdata;
          if (illegal)
            state_d = S_ERR;
          else if (bus.req_write && bus.req_funct == FUNCT_W)
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = write_q ? S_MRG : S_LEXT;
      end
      S_LEXT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = a_ext;
        state_d      = S_IDLE;
      end
      S_MRG: begin
        word_d  = a_merged;
        state_d = S_WR;
      end
      S_WR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        state_d      = S_IDLE;
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_error_d = 1'b1;
        resp_rdata_d = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      funct_q      <= '0;
      addr_q       <= '0;
      word_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct_q      <= funct_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready      = idle;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_read       = (state_q == S_RD);
  assign bus.mem_write      = (state_q == S_WR);
  assign bus.mem_address    = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
  assign bus.mem_write_data = (state_q == S_WR) ? word_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered memory.
// Driver pushes expectations; negedge monitor pops and compares.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic reset;
  logic init;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;
  int   rd_cnt = 0;
  int   rd_exp = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] data;
  } wr_t;

  exp_t sbq[$];
  wr_t  wq[$];

  logic [31:0] mem [0:31];
  logic [31:0] rdq;

  load_store_unit_if bus();

  load_store_unit #(.DEPTH(32), .IDX_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered word memory: read data appears the cycle after mem_read.
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h12345678;
      mem[31] <= 32'hCAFEF00D;
      rdq     <= 32'h0;
    end else begin
      if (bus.mem_read) rdq <= mem[bus.mem_address[4:0]];
      if (bus.mem_write) mem[bus.mem_address[4:0]] <= bus.mem_write_data;
    end
  end
  assign bus.mem_read_data = rdq;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && !init) begin
      if (bus.mem_read && bus.mem_write) begin
        fails++;
        $display("FAIL strobe_excl: both strobes high at cycle %0d", cyc);
      end
      if (bus.mem_read) rd_cnt++;
      if (bus.mem_write) begin
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: idx %h data %h",
                   bus.mem_address, bus.mem_write_data);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_idx", bus.mem_address, w.idx);
          chk("wr_data", bus.mem_write_data, w.data);
        end
      end
      if (bus.resp_valid) begin
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: rdata %h err %b",
                   bus.resp_rdata, bus.resp_error);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_error", 32'(bus.resp_error), 32'(e.err));
          chk("resp_lat", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(
    input logic wr, input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] er, input logic ee,
    input int lat, input logic exp_w, input logic [31:0] widx,
    input logic [31:0] wdat, input int nrd, input logic push,
    input logic b2b
  );
    int n;
    exp_t e;
    wr_t w;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_funct = f;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      fails++;
      $display("FAIL accept_timeout: addr %h got ready 0 expected 1", a);
    end
    if (b2b) chk("b2b_accept", 32'(bus.resp_valid), 32'd1);
    if (push) begin
      e = '{rdata: er, err: ee, acc: cyc + 1, lat: lat};
      sbq.push_back(e);
      if (exp_w) begin
        w = '{idx: widx, data: wdat};
        wq.push_back(w);
      end
    end
    rd_exp += nrd;
    @(posedge clk);
  endtask

  task automatic ld(input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] exp);
    issue(1'b0, f, a, 32'h0, exp, 1'b0, 3, 1'b0, 32'h0, 32'h0,
          1, 1'b1, 1'b0);
  endtask

  task automatic st(input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] wdat,
                    input logic b2b);
    logic w;
    w = (f == FUNCT_W);
    issue(1'b1, f, a, wd, 32'h0, 1'b0, w ? 2 : 4, 1'b1,
          {2'b00, a[31:2]}, wdat, w ? 0 : 1, 1'b1, b2b);
  endtask

  task automatic bad(input logic wr, input logic [2:0] f,
                     input logic [31:0] a);
    issue(wr, f, a, 32'hFFFFFFFF, 32'h0, 1'b1, 2, 1'b0, 32'h0,
          32'h0, 0, 1'b1, 1'b0);
  endtask

  task automatic idle_drain();
    int n;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sbq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    init          = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    init  = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    st(FUNCT_W,  32'h08, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    ld(FUNCT_B,  32'h0B, 32'hFFFFFFDE);
    ld(FUNCT_BU, 32'h0B, 32'h000000DE);
    ld(FUNCT_H,  32'h08, 32'hFFFFBEEF);
    ld(FUNCT_HU, 32'h0A, 32'h0000DEAD);
    st(FUNCT_B,  32'h09, 32'hFFFFFF11, 32'hDEAD11EF, 1'b0);
    ld(FUNCT_W,  32'h08, 32'hDEAD11EF);
    st(FUNCT_H,  32'h0A, 32'h12345678, 32'h567811EF, 1'b0);
    ld(FUNCT_B,  32'h08, 32'hFFFFFFEF);
    ld(FUNCT_H,  32'h0A, 32'h00005678);
    bad(1'b0, FUNCT_W,  32'h06);
    bad(1'b1, FUNCT_H,  32'h05);
    bad(1'b1, FUNCT_W,  32'h80);
    bad(1'b1, FUNCT_BU, 32'h08);
    bad(1'b0, 3'b011,   32'h00);
    ld(FUNCT_W,  32'h7C, 32'hCAFEF00D);
    idle_drain();

    ld(FUNCT_W,  32'h00, 32'h12345678);
    st(FUNCT_W,  32'h04, 32'h0BADF00D, 32'h0BADF00D, 1'b1);
    ld(FUNCT_W,  32'h04, 32'h0BADF00D);
    idle_drain();

    // Abort an SB while it sits in the merge state.
    issue(1'b1, FUNCT_B, 32'h09, 32'h22, 32'h0, 1'b0, 4, 1'b0,
          32'h0, 32'h0, 1, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_resp_error", 32'(bus.resp_error), 32'd0);
    chk("abort_mem_read", 32'(bus.mem_read), 32'd0);
    chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
    chk("abort_resp_rdata", bus.resp_rdata, 32'h0);
    chk("abort_mem_address", bus.mem_address, 32'h0);
    chk("abort_mem_wdata", bus.mem_write_data, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_mem_kept", mem[2], 32'h567811EF);
    ld(FUNCT_W, 32'h08, 32'h567811EF);
    idle_drain();

    repeat (3) @(negedge clk);
    chk("read_count", 32'(rd_cnt), 32'(rd_exp));
    chk("writes_left", 32'(wq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
